aes_result_drain: RTL and testbench

Downstream stage of the AES memory engine. After the engine signals completion, this block reads the result words out of the shared AES scratch memory, starting at the output base address and stopping at the 32'hDEADBEEF sentinel. It emits the words in address order on a valid/ready stream with a last flag. It then pulses done and reports how many words it emitted.

---
 rtl/aes_result_drain.sv | 222 ++++++++++++++++++++++
 tb/tb_aes_result_drain.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_drain.sv
// -----------------------------------------------------------------------------
// aes_result_drain
//
// Reads AES result words out of the shared scratch memory, starting at
// OUT_BASE_ADDR and stopping at the SENTINEL word (or after MAX_WORDS reads).
// The words go out in address order on a valid/ready stream. m_last_out marks
// the final word. A done pulse follows, and word_count_out reports how many
// words were emitted.
//
// Ports:
//   clk_in          - single clock
//   rst_in          - asynchronous active-low reset
//   start_in        - begin draining (sampled only while idle)
//   mem_rd_addr_out - registered scratch-memory read address (10b)
//   mem_data_in     - scratch-memory read data, RD_LATENCY+1 edges after addr
//   m_data_out      - stream data
//   m_valid_out     - stream valid
//   m_ready_in      - stream ready
//   m_last_out      - final result word, qualified by m_valid_out
//   busy_out        - high whenever not idle
//   done_out        - one-cycle pulse when draining ends
//   word_count_out  - words emitted by the last drain
//   overflow_out    - sticky: MAX_WORDS read without a sentinel
// -----------------------------------------------------------------------------
module aes_result_drain #(
  parameter int unsigned OUT_BASE_ADDR = 257,
  parameter int unsigned MAX_WORDS     = 256,
  parameter int unsigned RD_LATENCY    = 2,
  parameter logic [31:0] SENTINEL      = 32'hDEADBEEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic [9:0]  mem_rd_addr_out,
  input  logic [31:0] mem_data_in,
  output logic [31:0] m_data_out,
  output logic        m_valid_out,
  input  logic        m_ready_in,
  output logic        m_last_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [9:0]  word_count_out,
  output logic        overflow_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_CHK, S_PRESENT, S_DONE
  } state_e;

  localparam int             LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [9:0]     BASE     = 10'(OUT_BASE_ADDR);
  localparam logic [9:0]     MAX_PTR  = 10'(MAX_WORDS);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

  state_e             state_q, state_d;
  logic [9:0]         ptr_q, ptr_d;
  logic [31:0]        hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic [31:0]        look_q, look_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [9:0]         count_q, count_d;
  logic [9:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [9:0]         wcount_q, wcount_d;
  logic               ovf_q, ovf_d;
  logic               end_path;

  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    look_d    = look_q;
    lat_cnt_d = lat_cnt_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    wcount_d  = wcount_q;
    ovf_d     = ovf_q;
    end_path  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          ptr_d    = '0;
          hold_v_d = 1'b0;
          count_d  = '0;
          ovf_d    = 1'b0;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        if (ptr_q == MAX_PTR) begin
          // Read budget exhausted: finish as if the sentinel had been seen.
          ovf_d    = 1'b1;
          end_path = 1'b1;
        end else begin
          addr_d    = BASE + ptr_q;
          lat_cnt_d = '0;
          state_d   = (RD_LATENCY == 0) ? S_CHK : S_WAIT;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) state_d = S_CHK;
      end
      S_CHK: begin
        if (mem_data_in == SENTINEL) begin
          end_path = 1'b1;
        end else if (!hold_v_q) begin
          // First word: park it until its successor is known.
          hold_d   = mem_data_in;
          hold_v_d = 1'b1;
          ptr_d    = ptr_q + 1'b1;
          state_d  = S_RD;
        end else begin
          // Successor is real data, so the held word is not the last one.
          look_d  = mem_data_in;
          ptr_d   = ptr_q + 1'b1;
          data_d  = hold_q;
          last_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (m_ready_in) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          count_d = count_q + 1'b1;
          if (last_q) begin
            // Count is published together with the done pulse.
            done_d   = 1'b1;
            wcount_d = count_q + 1'b1;
            state_d  = S_DONE;
          end else begin
            hold_d  = look_q;
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared end-of-result path (sentinel found or read budget exhausted).
    if (end_path) begin
      if (hold_v_q) begin
        data_d  = hold_q;
        last_d  = 1'b1;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end else begin
        done_d   = 1'b1;
        wcount_d = count_q;
        state_d  = S_DONE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath
  // registers (hold, look) are reset too, since reset must clear everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      look_q    <= '0;
      lat_cnt_q <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wcount_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      look_q    <= look_d;
      lat_cnt_q <= lat_cnt_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wcount_q  <= wcount_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mem_rd_addr_out = addr_q;
  assign m_data_out      = data_q;
  assign m_valid_out     = valid_q;
  assign m_last_out      = last_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign word_count_out  = wcount_q;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_aes_result_drain.sv
// -----------------------------------------------------------------------------
// tb_aes_result_drain
//
// Self-checking bench for aes_result_drain. A behavioural scratch memory with a
// two-register read pipeline (RD_LATENCY=2) feeds two instances: the default
// configuration, and one with MAX_WORDS=4 for the overflow scenario. Expected
// {last,data} beats are queued when memory is loaded and popped on handshakes.
// -----------------------------------------------------------------------------
module tb_aes_result_drain;

  localparam logic [31:0] SENT = 32'hDEADBEEF;
  localparam int          BASE = 257;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_a, start_b, ready;
  logic [9:0]  addr_a, addr_b, wc_a, wc_b;
  logic [31:0] rdata_a, rdata_b, pipe_a, pipe_b, data_a, data_b;
  logic        valid_a, valid_b, last_a, last_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  logic [31:0] mem [0:1023];
  logic [32:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_in = ~clk_in;

  // Scratch memory: data for an address registered at edge E is visible after
  // edge E+2 and therefore sampled correctly at edge E+3.
  always @(posedge clk_in) begin
    pipe_a  <= mem[addr_a];
    rdata_a <= pipe_a;
    pipe_b  <= mem[addr_b];
    rdata_b <= pipe_b;
  end

  aes_result_drain #(.RD_LATENCY(2)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_a),
    .mem_rd_addr_out(addr_a), .mem_data_in(rdata_a),
    .m_data_out(data_a), .m_valid_out(valid_a), .m_ready_in(ready),
    .m_last_out(last_a), .busy_out(busy_a), .done_out(done_a),
    .word_count_out(wc_a), .overflow_out(ovf_a)
  );

  aes_result_drain #(.RD_LATENCY(2), .MAX_WORDS(4)) u_dut_ovf (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b),
    .mem_rd_addr_out(addr_b), .mem_data_in(rdata_b),
    .m_data_out(data_b), .m_valid_out(valid_b), .m_ready_in(ready),
    .m_last_out(last_b), .busy_out(busy_b), .done_out(done_b),
    .word_count_out(wc_b), .overflow_out(ovf_b)
  );

  // Loads n data words at BASE, optionally followed by the sentinel, and
  // queues the beats the DUT should produce (last on the final emitted word).
  task automatic load_words(input logic [31:0] seed, input int n, input bit sentinel,
                            input int n_emit);
    logic [31:0] w;
    sb.delete();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    for (int i = 0; i < n; i++) begin
      w = seed + 32'(i);
      mem[BASE + i] = w;
      if (i < n_emit) sb.push_back({(i == n_emit - 1), w});
    end
    if (sentinel) mem[BASE + n] = SENT;
  endtask

  // Pulses start, then runs until done has pulsed and busy has dropped,
  // checking every beat, stall stability and the final status.
  task automatic run_stream(input bit use_b, input int duty, input int exp_words,
                            input int exp_first, input int exp_done_k, input bit exp_ovf,
                            input int exp_max_addr, input int restart_at);
    int          k = 0, beats = 0, dones = 0, first = -1, done_k = -1, max_addr = 0;
    bit          pv = 1'b0, pr = 1'b0, prev_done = 1'b0, finished = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic        v, l, b, d;
    logic [31:0] dat;
    logic [9:0]  a;
    logic [32:0] exp;

    @(negedge clk_in);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk_in);
    if (use_b) start_b = 1'b0; else start_a = 1'b0;

    while (k < 600 && !finished) begin
      if (use_b) begin
        v = valid_b; l = last_b; b = busy_b; d = done_b; dat = data_b; a = addr_b;
      end else begin
        v = valid_a; l = last_a; b = busy_a; d = done_a; dat = data_a; a = addr_a;
        start_a = (k == restart_at);
      end
      ready = ($urandom_range(99) < duty);
      if (k >= 1 && int'(a) > max_addr) max_addr = int'(a);

      if (pv && !pr) begin
        n_checks++;
        if (v !== 1'b1 || dat !== pd || l !== pl) begin
          n_fail++;
          $display("FAIL stall_stable k=%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   k, v, dat, l, pd, pl);
        end
      end
      if (prev_done) begin
        n_checks++;
        if (b !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_done: got busy=%b expected 0", b);
        end
        finished = 1'b1;
      end
      if (v === 1'b1 && first < 0) first = k;
      if (d === 1'b1) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (v === 1'b1 && ready) begin
        beats++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got data=%h last=%b expected no beat", dat, l);
        end else begin
          exp = sb.pop_front();
          if ({l, dat} !== exp) begin
            n_fail++;
            $display("FAIL beat%0d: got last=%b data=%h expected last=%b data=%h",
                     beats, l, dat, exp[32], exp[31:0]);
          end
        end
      end
      prev_done = (d === 1'b1);
      pv = (v === 1'b1); pr = ready; pd = dat; pl = l;
      @(negedge clk_in);
      k++;
    end
    start_a = 1'b0;
    ready   = 1'b0;

    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: got %0d cycles without done expected completion", k);
    end
    n_checks++;
    if (beats != exp_words || sb.size() != 0) begin
      n_fail++;
      $display("FAIL beat_count: got %0d beats (%0d unsent) expected %0d",
               beats, sb.size(), exp_words);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d expected 1", dones);
    end
    n_checks++;
    if (first != exp_first) begin
      n_fail++;
      $display("FAIL first_valid_cycle: got %0d expected %0d", first, exp_first);
    end
    if (exp_done_k >= 0) begin
      n_checks++;
      if (done_k != exp_done_k) begin
        n_fail++;
        $display("FAIL done_cycle: got %0d expected %0d", done_k, exp_done_k);
      end
    end
    n_checks++;
    if ((use_b ? wc_b : wc_a) !== 10'(exp_words)) begin
      n_fail++;
      $display("FAIL word_count: got %0d expected %0d", use_b ? wc_b : wc_a, exp_words);
    end
    n_checks++;
    if ((use_b ? ovf_b : ovf_a) !== exp_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b", use_b ? ovf_b : ovf_a, exp_ovf);
    end
    n_checks++;
    if (max_addr != exp_max_addr) begin
      n_fail++;
      $display("FAIL max_read_addr: got %0d expected %0d", max_addr, exp_max_addr);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({addr_a, data_a, valid_a, last_a, busy_a, done_a, wc_a, ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d data=%h v=%b l=%b busy=%b done=%b wc=%0d ovf=%b expected all 0",
               addr_a, data_a, valid_a, last_a, busy_a, done_a, wc_a, ovf_a);
    end
    n_checks++;
    if ({busy_b, valid_b, ovf_b, wc_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_ovf_inst: got busy=%b v=%b ovf=%b wc=%0d expected all 0",
               busy_b, valid_b, ovf_b, wc_b);
    end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_basic();
    load_words(32'hA0, 4, 1'b1, 4);
    run_stream(1'b0, 100, 4, 8, -1, 1'b0, 261, -1);
  endtask

  task automatic test_sentinel_only();
    load_words(32'h0, 0, 1'b1, 0);
    run_stream(1'b0, 100, 0, -1, 4, 1'b0, 257, -1);
  endtask

  task automatic test_backpressure();
    load_words(32'hC0DE_0100, 4, 1'b1, 4);
    run_stream(1'b0, 30, 4, 8, -1, 1'b0, 261, -1);
  endtask

  task automatic test_overflow();
    load_words(32'hB000_0000, 5, 1'b0, 4);
    run_stream(1'b1, 100, 4, 8, -1, 1'b1, 260, -1);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int beats = 0;
    load_words(32'hA0, 4, 1'b1, 4);
    @(negedge clk_in);
    start_a = 1'b1;
    @(negedge clk_in);
    start_a = 1'b0;
    ready   = 1'b1;
    while (k < 200 && !(valid_a === 1'b1 && beats == 1)) begin
      if (valid_a === 1'b1) beats++;
      @(negedge clk_in);
      k++;
    end
    ready = 1'b0;
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 32'hA1) begin
      n_fail++;
      $display("FAIL second_word_pending: got v=%b data=%h expected v=1 data=000000a1",
               valid_a, data_a);
    end
    #2 rst_in = 1'b0;
    #1;
    n_checks++;
    if ({addr_a, data_a, valid_a, last_a, busy_a, done_a, wc_a, ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got addr=%0d data=%h v=%b l=%b busy=%b done=%b wc=%0d ovf=%b expected all 0",
               addr_a, data_a, valid_a, last_a, busy_a, done_a, wc_a, ovf_a);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    load_words(32'hA0, 4, 1'b1, 4);
    run_stream(1'b0, 100, 4, 8, -1, 1'b0, 261, -1);
  endtask

  task automatic test_start_ignored();
    load_words(32'h5100_0000, 4, 1'b1, 4);
    run_stream(1'b0, 100, 4, 8, -1, 1'b0, 261, 14);
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    ready   = 1'b0;
    rst_in  = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_sentinel_only();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
